// File: rtl/scroll_counter_gen_pkg.sv
// Shared definitions for the scroll position counter: step direction,
// index-width helper and the CLK10-to-pixel-rate divider.
package scroll_counter_gen_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int unsigned PIX_DIV = 2;

  // Width of a register/player index; a single-entry bank still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/scroll_step_core.sv
// Loadable modulo up/down counter: steps once per step strobe and pulses
// wrap_n low for the single cycle in which it wraps.
module scroll_step_core
  import scroll_counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned WRAP_MAX = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             step,
  input  dir_e             dir,
  output logic [WIDTH-1:0] count,
  output logic             wrap_n
);

  localparam logic [WIDTH-1:0] WMAX = WIDTH'(WRAP_MAX);

  logic [WIDTH-1:0] count_nxt;
  logic             wrap;

  // Values above WMAX (loaded directly) roll to 0 going up, and simply
  // decrement going down; only the modular boundary counts as a wrap.
  always_comb begin
    count_nxt = count;
    wrap      = 1'b0;
    if (dir == DIR_UP) begin
      if (count >= WMAX) begin
        count_nxt = '0;
        wrap      = 1'b1;
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end else begin
      if (count == '0) begin
        count_nxt = WMAX;
        wrap      = 1'b1;
      end else begin
        count_nxt = count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      wrap_n <= 1'b1;
    end else if (load) begin
      count  <= load_val;
      wrap_n <= 1'b1;
    end else if (step) begin
      count  <= count_nxt;
      wrap_n <= ~wrap;
    end else begin
      wrap_n <= 1'b1;
    end
  end

endmodule

// File: rtl/scroll_counter_gen.sv
// Per-player scroll register bank, pixel-rate prescaler and load/enable
// gating around a modulo up/down position counter feeding the playfield.
module scroll_counter_gen
  import scroll_counter_gen_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned STEP_DIV    = PIX_DIV,
  parameter int unsigned WRAP_MAX    = (1 << WIDTH) - 1
) (
  input  logic                                CLK10,
  input  logic                                RESETn,
  input  logic [WIDTH-1:0]                    BD,
  input  logic                                WRn,
  input  logic [idx_w(NUM_PLAYERS)-1:0]       WSEL,
  input  logic [idx_w(NUM_PLAYERS)-1:0]       PSEL,
  input  logic                                HSLDn,
  input  logic                                HBLANK1n,
  input  logic                                VBLANK,
  output logic [WIDTH-1:0]                    HL,
  output logic                                TCn
);

  localparam int unsigned IW = idx_w(NUM_PLAYERS);
  localparam int unsigned PW = (STEP_DIV <= 1) ? 1 : $clog2(STEP_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);

  logic [WIDTH-1:0] scroll_reg [NUM_PLAYERS];
  logic [WIDTH-1:0] load_val;
  logic [PW-1:0]    presc;
  logic             run;
  logic             load;
  logic             step;
  dir_e             dir;

  assign run  = HBLANK1n & ~VBLANK;
  assign load = ~HSLDn;
  assign step = run & ~load & (presc == PRE_LAST);
  assign dir  = dir_e'(PSEL[0]);

  // Out-of-range indices match no entry: writes drop, loads read zero.
  always_comb begin
    load_val = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (PSEL == IW'(i)) load_val = scroll_reg[i];
    end
  end

  always_ff @(posedge CLK10 or negedge RESETn) begin
    if (!RESETn) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) scroll_reg[i] <= '0;
    end else if (!WRn) begin
      for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
        if (WSEL == IW'(i)) scroll_reg[i] <= BD;
      end
    end
  end

  // Prescaler holds its phase across blanking so a step resumes mid-count.
  always_ff @(posedge CLK10 or negedge RESETn) begin
    if (!RESETn) begin
      presc <= '0;
    end else if (load) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
    end
  end

  scroll_step_core #(
    .WIDTH    (WIDTH),
    .WRAP_MAX (WRAP_MAX)
  ) u_core (
    .clk      (CLK10),
    .rst_n    (RESETn),
    .load     (load),
    .load_val (load_val),
    .step     (step),
    .dir      (dir),
    .count    (HL),
    .wrap_n   (TCn)
  );

endmodule

// File: tb/tb_scroll_counter_gen.sv
// Directed bench for two scroll_counter_gen instances (default 8-bit and a
// 10-bit/3-player/modulo-640 variant) against a behavioural model.
module tb_scroll_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: defaults
  logic       rst_a = 1'b0, wrn_a = 1'b1, hsldn_a = 1'b1, hb_a = 1'b0, vb_a = 1'b1;
  logic [7:0] bd_a = '0, hl_a;
  logic       wsel_a = 1'b0, psel_a = 1'b0, tc_a;

  // Instance B: WIDTH=10, NUM_PLAYERS=3, STEP_DIV=1, WRAP_MAX=639
  logic       rst_b = 1'b0, wrn_b = 1'b1, hsldn_b = 1'b1, hb_b = 1'b0, vb_b = 1'b1;
  logic [9:0] bd_b = '0, hl_b;
  logic [1:0] wsel_b = '0, psel_b = '0;
  logic       tc_b;

  scroll_counter_gen dut_a (
    .CLK10(clk), .RESETn(rst_a), .BD(bd_a), .WRn(wrn_a), .WSEL(wsel_a),
    .PSEL(psel_a), .HSLDn(hsldn_a), .HBLANK1n(hb_a), .VBLANK(vb_a),
    .HL(hl_a), .TCn(tc_a)
  );

  scroll_counter_gen #(
    .WIDTH(10), .NUM_PLAYERS(3), .STEP_DIV(1), .WRAP_MAX(639)
  ) dut_b (
    .CLK10(clk), .RESETn(rst_b), .BD(bd_b), .WRn(wrn_b), .WSEL(wsel_b),
    .PSEL(psel_b), .HSLDn(hsldn_b), .HBLANK1n(hb_b), .VBLANK(vb_b),
    .HL(hl_b), .TCn(tc_b)
  );

  int checks = 0;
  int failures = 0;

  // Model state: registers, position, prescaler phase, wrap flag.
  int unsigned m_reg [2][4];
  int unsigned m_hl  [2];
  int unsigned m_pre [2];
  bit          m_tc  [2];

  task automatic model_reset(input int k);
    for (int i = 0; i < 4; i++) m_reg[k][i] = 0;
    m_hl[k] = 0; m_pre[k] = 0; m_tc[k] = 1'b1;
  endtask

  task automatic model_edge(input int k, input int unsigned wmax, input int unsigned sdiv,
                            input int unsigned np, input bit wrn, input int unsigned wsel,
                            input int unsigned psel, input bit hsldn, input bit run,
                            input int unsigned bd);
    int unsigned src;
    src = (psel < np) ? m_reg[k][psel] : 0;
    m_tc[k] = 1'b1;
    if (!hsldn) begin
      m_hl[k] = src;
      m_pre[k] = 0;
    end else if (run) begin
      if (m_pre[k] + 1 == sdiv) begin
        m_pre[k] = 0;
        if (psel % 2 == 0) begin
          if (m_hl[k] >= wmax) begin m_hl[k] = 0; m_tc[k] = 1'b0; end
          else m_hl[k] = m_hl[k] + 1;
        end else begin
          if (m_hl[k] == 0) begin m_hl[k] = wmax; m_tc[k] = 1'b0; end
          else m_hl[k] = m_hl[k] - 1;
        end
      end else begin
        m_pre[k] = m_pre[k] + 1;
      end
    end
    if (!wrn && wsel < np) m_reg[k][wsel] = bd;
  endtask

  always @(posedge clk or negedge rst_a)
    if (!rst_a) model_reset(0);
    else model_edge(0, 255, 2, 2, wrn_a, 32'(wsel_a), 32'(psel_a), hsldn_a, hb_a & ~vb_a, 32'(bd_a));

  always @(posedge clk or negedge rst_b)
    if (!rst_b) model_reset(1);
    else model_edge(1, 639, 1, 3, wrn_b, 32'(wsel_b), 32'(psel_b), hsldn_b, hb_b & ~vb_b, 32'(bd_b));

  always @(negedge clk) begin
    if (rst_a) begin
      checks++;
      if (32'(hl_a) !== m_hl[0] || tc_a !== m_tc[0]) begin
        failures++;
        $display("FAIL model_a t=%0t HL=%0d TCn=%0b expected HL=%0d TCn=%0b",
                 $time, hl_a, tc_a, m_hl[0], m_tc[0]);
      end
    end
    if (rst_b) begin
      checks++;
      if (32'(hl_b) !== m_hl[1] || tc_b !== m_tc[1]) begin
        failures++;
        $display("FAIL model_b t=%0t HL=%0d TCn=%0b expected HL=%0d TCn=%0b",
                 $time, hl_b, tc_b, m_hl[1], m_tc[1]);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int unsigned act_hl, input logic act_tc,
                     input int unsigned exp_hl, input logic exp_tc);
    checks++;
    if (act_hl !== exp_hl || act_tc !== exp_tc) begin
      failures++;
      $display("FAIL %s HL=0x%0h TCn=%0b expected HL=0x%0h TCn=%0b",
               name, act_hl, act_tc, exp_hl, exp_tc);
    end
  endtask

  task automatic wr_a(input logic sel, input logic [7:0] d);
    wrn_a = 1'b0; wsel_a = sel; bd_a = d; tick(); wrn_a = 1'b1;
  endtask

  task automatic ld_a(input logic sel);
    psel_a = sel; hsldn_a = 1'b0; tick(); hsldn_a = 1'b1;
  endtask

  task automatic wr_b(input logic [1:0] sel, input logic [9:0] d);
    wrn_b = 1'b0; wsel_b = sel; bd_b = d; tick(); wrn_b = 1'b1;
  endtask

  task automatic ld_b(input logic [1:0] sel);
    psel_b = sel; hsldn_b = 1'b0; tick(); hsldn_b = 1'b1;
  endtask

  task automatic run_a(input logic on);
    hb_a = on; vb_a = ~on;
  endtask

  task automatic run_b(input logic on);
    hb_b = on; vb_b = ~on;
  endtask

  initial begin
    tick(2);
    chk("reset_a", 32'(hl_a), tc_a, 'h00, 1'b1);
    chk("reset_b", 32'(hl_b), tc_b, 0, 1'b1);
    rst_a = 1'b1; rst_b = 1'b1;

    // Write and load
    wr_a(1'b0, 8'h10);
    ld_a(1'b0);
    chk("load_0x10", 32'(hl_a), tc_a, 'h10, 1'b1);

    // Up count, one step every second edge
    run_a(1'b1);
    tick();  chk("up_e1", 32'(hl_a), tc_a, 'h10, 1'b1);
    tick();  chk("up_e2", 32'(hl_a), tc_a, 'h11, 1'b1);
    tick(6); chk("up_e8", 32'(hl_a), tc_a, 'h14, 1'b1);
    run_a(1'b0);

    // Wrap up through 0xFF
    wr_a(1'b0, 8'hFE);
    ld_a(1'b0);
    run_a(1'b1);
    tick(2); chk("up_ff", 32'(hl_a), tc_a, 'hFF, 1'b1);
    tick(2); chk("up_wrap", 32'(hl_a), tc_a, 'h00, 1'b0);
    tick();  chk("up_wrap_end", 32'(hl_a), tc_a, 'h00, 1'b1);
    run_a(1'b0);

    // Flipped player counts down
    wr_a(1'b1, 8'h01);
    ld_a(1'b1);
    run_a(1'b1);
    tick(2); chk("dn_00", 32'(hl_a), tc_a, 'h00, 1'b1);
    tick(2); chk("dn_wrap", 32'(hl_a), tc_a, 'hFF, 1'b0);
    run_a(1'b0);

    // Blanking freezes HL and prescaler phase
    psel_a = 1'b0;
    wr_a(1'b0, 8'h20);
    ld_a(1'b0);
    run_a(1'b1); tick();
    hb_a = 1'b0; tick(5);
    chk("hblank_hold", 32'(hl_a), tc_a, 'h20, 1'b1);
    hb_a = 1'b1; tick();
    chk("hblank_resume", 32'(hl_a), tc_a, 'h21, 1'b1);
    tick();
    vb_a = 1'b1; tick(5);
    chk("vblank_hold", 32'(hl_a), tc_a, 'h21, 1'b1);
    vb_a = 1'b0; tick();
    chk("vblank_resume", 32'(hl_a), tc_a, 'h22, 1'b1);

    // Load + step due + write to same register on one edge
    tick();
    psel_a = 1'b0; hsldn_a = 1'b0; wrn_a = 1'b0; wsel_a = 1'b0; bd_a = 8'h55;
    tick();
    hsldn_a = 1'b1; wrn_a = 1'b1;
    chk("prio_old_val", 32'(hl_a), tc_a, 'h20, 1'b1);
    run_a(1'b0);
    ld_a(1'b0);
    chk("prio_new_val", 32'(hl_a), tc_a, 'h55, 1'b1);

    // Instance B: modulo 640, step every run edge
    wr_b(2'd0, 10'd638);
    ld_b(2'd0);
    run_b(1'b1);
    tick(); chk("b_639", 32'(hl_b), tc_b, 639, 1'b1);
    tick(); chk("b_wrap", 32'(hl_b), tc_b, 0, 1'b0);
    run_b(1'b0);
    wr_b(2'd0, 10'd700);
    ld_b(2'd0);
    chk("b_load_700", 32'(hl_b), tc_b, 700, 1'b1);
    run_b(1'b1); tick(); run_b(1'b0);
    chk("b_700_up", 32'(hl_b), tc_b, 0, 1'b0);
    wr_b(2'd1, 10'd700);
    ld_b(2'd1);
    run_b(1'b1); tick(); run_b(1'b0);
    chk("b_700_dn", 32'(hl_b), tc_b, 699, 1'b1);
    psel_b = 2'd1;
    run_b(1'b1); tick(); run_b(1'b0);
    chk("b_698_dn", 32'(hl_b), tc_b, 698, 1'b1);

    // Out-of-range index: write dropped, load gives 0
    wr_b(2'd2, 10'd5);
    wr_b(2'd3, 10'h3FF);
    ld_b(2'd3);
    chk("b_psel_oor", 32'(hl_b), tc_b, 0, 1'b1);
    ld_b(2'd2);
    chk("b_reg2_kept", 32'(hl_b), tc_b, 5, 1'b1);

    // Asynchronous reset mid-line, then count from 0 without a load
    psel_b = 2'd2;
    run_b(1'b1); tick(3);
    chk("b_run_8", 32'(hl_b), tc_b, 8, 1'b1);
    #1 rst_b = 1'b0;
    #1 chk("b_async_rst", 32'(hl_b), tc_b, 0, 1'b1);
    @(negedge clk); rst_b = 1'b1;
    tick(2);
    chk("b_after_rst", 32'(hl_b), tc_b, 2, 1'b1);
    run_b(1'b0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scroll_counter_gen.md
Name: scroll_counter_gen

Overview:
Parametrised horizontal/vertical scroll position counter: the successor of the fixed 8-bit playfield scroll counter.
- Holds one scroll register per player, written from the CPU data bus.
- Loads the active player's value into a position counter on a load strobe.
- Steps that counter up or down, cocktail-flipped by player, at a programmable pixel rate during active video.
- Wraps at a programmable modulus and flags each wrap.
- Sits between the CPU bus decode and the playfield address generator; its output HL indexes the playfield RAM column.

Parameters:
WIDTH, 8, counter, scroll register and bus width in bits
NUM_PLAYERS, 2, number of scroll registers (one per player); min 1
STEP_DIV, 2, CLK10 cycles per counter step (2 = 5 MHz pixel rate); min 1
WRAP_MAX, 2**WIDTH-1, highest counter value before wrap; must be < 2**WIDTH

Ports:
CLK10  in  1  system clock, all state on rising edge
RESETn  in  1  asynchronous active-low reset
BD  in  WIDTH  CPU data bus, scroll register write data
WRn  in  1  active-low scroll register write strobe, sampled per CLK10 edge
WSEL  in  clog2(NUM_PLAYERS) max 1  scroll register index for writes
PSEL  in  clog2(NUM_PLAYERS) max 1  active player; selects the load source; LSB set = flipped
HSLDn  in  1  active-low counter load strobe
HBLANK1n  in  1  active-low horizontal blank (1 = active line)
VBLANK  in  1  active-high vertical blank
HL  out  WIDTH  registered scroll position
TCn  out  1  registered active-low wrap flag, one cycle

Behaviour:
- Reset (async, RESETn=0):
  - all scroll registers, HL and the prescaler go to 0; TCn goes to 1.
  - Reset release is synchronous-safe: the first edge after release behaves as normal operation.
- Register write:
  - WRn=0 at an edge writes BD to reg[WSEL].
  - WSEL >= NUM_PLAYERS: ignored.
- Enable: run = HBLANK1n & ~VBLANK.
- Load:
  - HSLDn=0 at an edge: HL <= reg[PSEL] (the pre-edge value, even if the same register is written that edge); prescaler <= 0; TCn <= 1.
  - Load has priority over counting, regardless of run.
  - PSEL >= NUM_PLAYERS loads 0.
- Prescaler:
  - When run=1 and no load, the prescaler increments modulo STEP_DIV.
  - A step occurs on an edge where the prescaler == STEP_DIV-1.
  - run=0 freezes both the prescaler and HL (no reset of the prescaler).
  - STEP_DIV=1: step on every run edge.
- Direction: PSEL[0]=0 steps up, PSEL[0]=1 steps down (flipped cocktail player). Direction is sampled on the step edge.
- Arithmetic:
  - Up step: HL >= WRAP_MAX ? 0 : HL+1.
  - Down step: HL == 0 ? WRAP_MAX : HL-1; a value > WRAP_MAX still decrements normally.
  - A loaded value > WRAP_MAX is accepted as-is.
- Wrap flag:
  - TCn <= 0 on the step edge that wraps (up to 0, or down to WRAP_MAX); otherwise TCn <= 1.
  - TCn is aligned with the HL update and lasts exactly one CLK10 cycle.
- Latency:
  - write to register: 1 cycle.
  - load to HL: 1 cycle.
  - step to HL: 1 cycle.
  - No combinational input-to-output paths.
- Simultaneous events:
  - load + step: load wins, no TCn.
  - write + load of the same register: old value loaded, new value stored.
- Reset mid-line: immediate clear; counting resumes from 0 on the next run window without needing a load.
- With the defaults, the block is cycle-equivalent to the legacy 8-bit dual-nibble up/down counter with an enable on the CLK5-low phase, plus the register bank and TCn.

Decomposition:
- Shared package holds:
  - the direction encoding constants DIR_UP=0, DIR_DOWN=1;
  - the clog2-based index width function used for WSEL/PSEL;
  - the CLK10/pixel-rate constant PIX_DIV=2 referenced by STEP_DIV.
- One natural sub-module, scroll_step_core: a WIDTH-bit loadable modulo up/down counter with a step input and a wrap output. The top module holds the register bank, the prescaler and load/enable gating.

Test Plan:
- Reset/write/load: assert RESETn=0 then release, with WIDTH=8 and STEP_DIV=2 -> HL=0, TCn=1. Write reg0=0x10, PSEL=0, HSLDn pulse -> HL=0x10 one edge later.
- Up count: run for 8 edges -> HL=0x14, steps every 2nd edge. Load 0xFE, run 4 edges -> HL=0xFF then 0x00 with TCn=0 for exactly one cycle.
- Down/flip: write reg1=0x01, PSEL=1, load, run 4 edges -> HL=0x00 then 0xFF (TCn=0 on the 0xFF edge).
- Blanking gate: during a count set HBLANK1n=0 for 5 edges then release -> HL and the prescaler are frozen; the first step comes after the remaining prescaler count. The same holds for VBLANK=1.
- Priority: on the same edge, HSLDn=0, a step due, and WRn=0 to reg[PSEL] with 0x55 -> HL = the old register value, TCn=1, register reads 0x55 on the next load.
- Generic instance WIDTH=10, WRAP_MAX=639, STEP_DIV=1: load 638, run 2 edges -> HL=639 then 0 with a TCn pulse. Load 700, step up -> 0. Reset asserted mid-line -> HL=0 asynchronously.
